// File: rtl/vend_sequencer.sv
// Vending machine transaction controller: credit, selection, dispense and change.
// Ports: coin/cancel/confirm/select/dispense_done in; balance/dispense/change/status out.
module vend_sequencer #(
  parameter int MAX_BAL      = 250,
  parameter int Q_VAL        = 25,
  parameter int D_VAL        = 100,
  parameter int DISP_TIMEOUT = 1000,
  parameter int CHANGE_GAP   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin_q,
  input  logic       coin_d,
  input  logic       cancel,
  input  logic       confirm,
  input  logic [2:0] select,
  input  logic       dispense_done,
  output logic [8:0] balance,
  output logic       dispense_req,
  output logic [2:0] product,
  output logic       change_pulse,
  output logic [3:0] change_cnt,
  output logic       coin_reject,
  output logic       sel_error,
  output logic       busy
);

  localparam int TW = $clog2(DISP_TIMEOUT + 1);
  localparam int GW = $clog2(CHANGE_GAP + 1);

  typedef enum logic [1:0] {
    IDLE, CREDIT, DISPENSE, CHANGE
  } state_t;

  state_t state, state_n;

  logic [8:0]    bal_n, price_q, price_n;
  logic [8:0]    sel_price, refund;
  logic [9:0]    acc;
  logic          req_n, pulse_n, rej_n;
  logic          serr_n, busy_n;
  logic [2:0]    prod_n;
  logic [3:0]    cnt_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [GW-1:0] gap, gap_n;

  function automatic logic [8:0] price_of(
    input logic [2:0] s
  );
    logic [8:0] p;
    case (s)
      3'd1:    p = 9'd75;
      3'd2:    p = 9'd100;
      3'd3:    p = 9'd125;
      3'd4:    p = 9'd150;
      3'd5:    p = 9'd175;
      3'd6:    p = 9'd200;
      3'd7:    p = 9'd250;
      default: p = 9'd0;
    endcase
    return p;
  endfunction

  function automatic logic [3:0] quarters(
    input logic [8:0] c
  );
    logic [8:0] q;
    q = c / 9'(Q_VAL);
    return q[3:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      balance      <= '0;
      dispense_req <= 1'b0;
      product      <= '0;
      change_pulse <= 1'b0;
      change_cnt   <= '0;
      coin_reject  <= 1'b0;
      sel_error    <= 1'b0;
      busy         <= 1'b0;
      price_q      <= '0;
      tmr          <= '0;
      gap          <= '0;
    end else begin
      state        <= state_n;
      balance      <= bal_n;
      dispense_req <= req_n;
      product      <= prod_n;
      change_pulse <= pulse_n;
      change_cnt   <= cnt_n;
      coin_reject  <= rej_n;
      sel_error    <= serr_n;
      busy         <= busy_n;
      price_q      <= price_n;
      tmr          <= tmr_n;
      gap          <= gap_n;
    end
  end

  always_comb begin
    state_n   = state;
    bal_n     = balance;
    req_n     = dispense_req;
    prod_n    = product;
    cnt_n     = change_cnt;
    pulse_n   = 1'b0;
    rej_n     = 1'b0;
    serr_n    = 1'b0;
    price_n   = price_q;
    tmr_n     = tmr;
    gap_n     = gap;
    refund    = '0;
    acc       = {1'b0, balance};
    sel_price = price_of(select);

    unique case (state)
      IDLE, CREDIT: begin
        if (cancel) begin
          rej_n   = coin_q | coin_d;
          cnt_n   = quarters(balance);
          bal_n   = '0;
          gap_n   = '0;
          state_n = (cnt_n != 4'd0) ? CHANGE : IDLE;
        end else if (confirm) begin
          rej_n = coin_q | coin_d;
          if (select == 3'd0 || balance < sel_price) begin
            serr_n = 1'b1;
          end else begin
            bal_n   = balance - sel_price;
            price_n = sel_price;
            prod_n  = select;
            req_n   = 1'b1;
            tmr_n   = '0;
            state_n = DISPENSE;
          end
        end else begin
          // quarter lands first; the dollar sees the updated credit
          if (coin_q) begin
            if (acc + 10'(Q_VAL) > 10'(MAX_BAL)) rej_n = 1'b1;
            else acc = acc + 10'(Q_VAL);
          end
          if (coin_d) begin
            if (acc + 10'(D_VAL) > 10'(MAX_BAL)) rej_n = 1'b1;
            else acc = acc + 10'(D_VAL);
          end
          bal_n   = acc[8:0];
          state_n = (acc == 10'd0) ? IDLE : CREDIT;
        end
      end
      DISPENSE: begin
        rej_n = coin_q | coin_d;
        if (dispense_done || tmr == TW'(DISP_TIMEOUT - 1)) begin
          // a motor timeout returns the price as well
          refund  = dispense_done ? balance : balance + price_q;
          req_n   = 1'b0;
          prod_n  = '0;
          bal_n   = '0;
          cnt_n   = quarters(refund);
          gap_n   = '0;
          state_n = (cnt_n != 4'd0) ? CHANGE : IDLE;
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      CHANGE: begin
        rej_n = coin_q | coin_d;
        if (gap == '0) begin
          pulse_n = 1'b1;
          cnt_n   = change_cnt - 4'd1;
          gap_n   = GW'(CHANGE_GAP - 1);
          if (change_cnt == 4'd1) state_n = IDLE;
        end else begin
          gap_n = gap - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n == DISPENSE) || (state_n == CHANGE);
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: directed scenarios then random traffic.
// Every cycle is compared against a transaction-level credit/refund model.
module tb_vend_sequencer;

  localparam int TMO = 1000;
  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       coin_q = 1'b0;
  logic       coin_d = 1'b0;
  logic       cancel = 1'b0;
  logic       confirm = 1'b0;
  logic [2:0] select = 3'd0;
  logic       dispense_done = 1'b0;
  logic [8:0] balance;
  logic       dispense_req;
  logic [2:0] product;
  logic       change_pulse;
  logic [3:0] change_cnt;
  logic       coin_reject;
  logic       sel_error;
  logic       busy;

  vend_sequencer dut (
    .clk(clk),
    .reset(reset),
    .coin_q(coin_q),
    .coin_d(coin_d),
    .cancel(cancel),
    .confirm(confirm),
    .select(select),
    .dispense_done(dispense_done),
    .balance(balance),
    .dispense_req(dispense_req),
    .product(product),
    .change_pulse(change_pulse),
    .change_cnt(change_cnt),
    .coin_reject(coin_reject),
    .sel_error(sel_error),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int npulse = 0;

  int price_tab [8] = '{0, 75, 100, 125, 150, 175, 200, 250};

  int m_bal = 0;
  int m_prod = 0;
  int m_price = 0;
  int m_n = 0;
  int m_paid = 0;
  int m_t0 = 0;
  int cyc = 0;
  bit m_disp = 0;
  bit m_chg = 0;
  bit e_pulse, e_rej, e_serr;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic refund(input int cents);
    m_bal  = 0;
    m_disp = 0;
    m_prod = 0;
    m_n    = cents / 25;
    m_paid = 0;
    m_t0   = cyc;
    m_chg  = (m_n > 0);
  endtask

  task automatic model();
    cyc++;
    e_pulse = 0;
    e_rej   = 0;
    e_serr  = 0;
    if (reset) begin
      m_bal = 0; m_disp = 0; m_chg = 0;
      m_prod = 0; m_n = 0; m_paid = 0;
    end else if (m_disp) begin
      e_rej = coin_q | coin_d;
      if (dispense_done) refund(m_bal);
      else if (cyc - m_t0 == TMO) refund(m_bal + m_price);
    end else if (m_chg) begin
      e_rej = coin_q | coin_d;
      if ((cyc - m_t0 - 1) % GAP == 0) begin
        e_pulse = 1;
        m_paid++;
        if (m_paid == m_n) m_chg = 0;
      end
    end else if (cancel) begin
      e_rej = coin_q | coin_d;
      refund(m_bal);
    end else if (confirm) begin
      e_rej = coin_q | coin_d;
      if (select == 0 || m_bal < price_tab[select]) begin
        e_serr = 1;
      end else begin
        m_price = price_tab[select];
        m_bal  -= m_price;
        m_prod  = int'(select);
        m_disp  = 1;
        m_t0    = cyc;
      end
    end else begin
      if (coin_q) begin
        if (m_bal + 25 > 250) e_rej = 1;
        else m_bal += 25;
      end
      if (coin_d) begin
        if (m_bal + 100 > 250) e_rej = 1;
        else m_bal += 100;
      end
    end
  endtask

  task automatic compare();
    chk("balance", balance, m_bal);
    chk("dispense_req", dispense_req, m_disp);
    chk("product", product, m_disp ? m_prod : 0);
    chk("change_pulse", change_pulse, e_pulse);
    chk("change_cnt", change_cnt,
        m_chg ? m_n - m_paid : 0);
    chk("coin_reject", coin_reject, e_rej);
    chk("sel_error", sel_error, e_serr);
    chk("busy", busy, m_disp | m_chg);
  endtask

  task automatic tick();
    @(posedge clk);
    model();
    #1;
    compare();
    if (change_pulse) npulse++;
    reset = 0; coin_q = 0; coin_d = 0;
    cancel = 0; confirm = 0; dispense_done = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      tick();
    end
    chk("drain_idle", busy, 0);
  endtask

  initial begin
    // reset state
    tick();
    chk("rst_bal", balance, 0);
    chk("rst_busy", busy, 0);

    // exact-price purchase, no change
    repeat (3) begin coin_q = 1; tick(); end
    chk("s1_bal75", balance, 75);
    select = 3'd1; confirm = 1; tick();
    chk("s1_bal0", balance, 0);
    chk("s1_req", dispense_req, 1);
    chk("s1_prod", product, 1);
    dispense_done = 1; tick();
    chk("s1_idle", busy, 0);
    npulse = 0;
    repeat (5) tick();
    chk("s1_nochg", npulse, 0);

    // purchase with 5 quarters change
    repeat (2) begin coin_d = 1; tick(); end
    select = 3'd1; confirm = 1; tick();
    chk("s2_bal125", balance, 125);
    dispense_done = 1; tick();
    chk("s2_cnt5", change_cnt, 5);
    npulse = 0;
    drain();
    chk("s2_pulses", npulse, 5);

    // credit ceiling
    coin_d = 1; tick(); coin_d = 1; tick();
    coin_q = 1; tick(); coin_q = 1; tick();
    chk("s3_bal250", balance, 250);
    coin_q = 1; tick();
    chk("s3_rej", coin_reject, 1);
    chk("s3_hold", balance, 250);
    cancel = 1; tick();
    chk("s3_cnt10", change_cnt, 10);
    drain();
    coin_d = 1; tick();
    coin_q = 1; tick(); coin_q = 1; tick();
    coin_q = 1; coin_d = 1; tick();
    chk("s3_bal175", balance, 175);
    chk("s3_rej2", coin_reject, 1);
    cancel = 1; tick();
    drain();

    // refused selections then cancel
    coin_d = 1; tick();
    select = 3'd3; confirm = 1; tick();
    chk("s4_serr", sel_error, 1);
    chk("s4_bal", balance, 100);
    select = 3'd0; confirm = 1; tick();
    chk("s4_serr0", sel_error, 1);
    cancel = 1; tick();
    npulse = 0;
    drain();
    chk("s4_pulses", npulse, 4);

    // cancel beats confirm and coins
    coin_q = 1; tick(); coin_q = 1; tick();
    select = 3'd1;
    cancel = 1; confirm = 1; coin_q = 1; tick();
    chk("s5_rej", coin_reject, 1);
    chk("s5_noreq", dispense_req, 0);
    chk("s5_cnt", change_cnt, 2);
    npulse = 0;
    drain();
    chk("s5_pulses", npulse, 2);

    // motor timeout refunds price plus remainder
    coin_d = 1; tick(); coin_q = 1; tick();
    select = 3'd2; confirm = 1; tick();
    repeat (TMO - 1) tick();
    chk("s6_req_hold", dispense_req, 1);
    tick();
    chk("s6_req_drop", dispense_req, 0);
    chk("s6_cnt", change_cnt, 5);
    npulse = 0;
    drain();
    chk("s6_pulses", npulse, 5);

    // reset in the middle of change
    coin_d = 1; tick(); coin_d = 1; tick();
    cancel = 1; tick();
    repeat (3) tick();
    reset = 1; tick();
    chk("s7_cnt", change_cnt, 0);
    chk("s7_busy", busy, 0);
    chk("s7_bal", balance, 0);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      coin_q  = ($urandom_range(0, 99) < 20);
      coin_d  = ($urandom_range(0, 99) < 10);
      cancel  = ($urandom_range(0, 99) < 4);
      confirm = ($urandom_range(0, 99) < 12);
      select  = 3'($urandom_range(0, 7));
      dispense_done = dispense_req &&
                      ($urandom_range(0, 99) < 5);
      reset   = ($urandom_range(0, 999) < 2);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
